// File: rtl/cpu_divider_if.sv
// Execute-stage <-> divider port group: issue side from execute, result side to the read FIFO.
interface cpu_divider_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  dest_reg;
  logic        abort;
  logic        busy;
  logic        div_valid;
  logic [31:0] div_result;
  logic [4:0]  div_dest_reg;

  modport master (
    output start, op, src_a, src_b, dest_reg, abort,
    input  busy, div_valid, div_result, div_dest_reg
  );

  modport slave (
    input  start, op, src_a, src_b, dest_reg, abort,
    output busy, div_valid, div_result, div_dest_reg
  );
endinterface

// File: rtl/cpu_divider.sv
// Iterative restoring divider for DIV/DIVU/MOD/MODU; one op in flight, N = 32/BITS_PER_CYCLE steps.
module cpu_divider #(
    parameter int BITS_PER_CYCLE = 1
) (
    input logic         clock,
    input logic         reset,
    cpu_divider_if.slave dif
);
    localparam int N = 32 / BITS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic [4:0]  dest_q;
    logic        neg_q, neg_r, div0;
    logic [31:0] dvs, rem, quo;
    logic [5:0]  cnt;

    logic        busy_q, valid_q;
    logic [31:0] result_q;
    logic [4:0]  dest_out_q;

    // Operand conditioning at issue: magnitudes for signed ops, raw for unsigned.
    logic        sa, sb;
    logic [31:0] a_mag, b_mag;
    assign sa    = ~dif.op[0] & dif.src_a[31];
    assign sb    = ~dif.op[0] & dif.src_b[31];
    assign a_mag = sa ? -dif.src_a : dif.src_a;
    assign b_mag = sb ? -dif.src_b : dif.src_b;

    // quo doubles as the dividend shift register: dividend bits leave the top, quotient bits enter the bottom.
    logic [BITS_PER_CYCLE:0][31:0] rem_s, quo_s;
    assign rem_s[0] = rem;
    assign quo_s[0] = quo;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        logic [32:0] trial, diff;
        assign trial        = {rem_s[i], quo_s[i][31]};
        assign diff         = trial - {1'b0, dvs};
        assign rem_s[i+1]   = diff[32] ? trial[31:0] : diff[31:0];
        assign quo_s[i+1]   = {quo_s[i][30:0], ~diff[32]};
    end

    logic [31:0] q_fin, r_fin, q_out, r_out, res;
    assign q_fin = quo_s[BITS_PER_CYCLE];
    assign r_fin = rem_s[BITS_PER_CYCLE];
    // Divide by zero naturally leaves rem=|a| (restored to src_a by the sign fix); only the quotient needs forcing.
    assign q_out = div0 ? 32'hFFFF_FFFF : (neg_q ? -q_fin : q_fin);
    assign r_out = neg_r ? -r_fin : r_fin;
    assign res   = op_q[1] ? r_out : q_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= '0;
            dest_q     <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div0       <= 1'b0;
            dvs        <= '0;
            rem        <= '0;
            quo        <= '0;
            cnt        <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            dest_out_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (dif.abort) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (dif.start) begin
                            op_q   <= dif.op;
                            dest_q <= dif.dest_reg;
                            neg_q  <= sa ^ sb;
                            neg_r  <= sa;
                            div0   <= (dif.src_b == 32'd0);
                            dvs    <= b_mag;
                            rem    <= '0;
                            quo    <= a_mag;
                            cnt    <= 6'(N);
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    RUN: begin
                        rem <= rem_s[BITS_PER_CYCLE];
                        quo <= quo_s[BITS_PER_CYCLE];
                        cnt <= cnt - 6'd1;
                        if (cnt == 6'd1) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            // Tag 0 means nobody wants the result; drop it without touching the outputs.
                            if (dest_q != 5'd0) begin
                                valid_q    <= 1'b1;
                                result_q   <= res;
                                dest_out_q <= dest_q;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign dif.busy         = busy_q;
    assign dif.div_valid    = valid_q;
    assign dif.div_result   = result_q;
    assign dif.div_dest_reg = dest_out_q;

endmodule
